cfg_region_query: RTL and testbench
===================================

Name: cfg_region_query

Overview:
- Reads the elaborated CVA6 physical-memory-attribute rule tables (Execute, Cached, NonIdempotent regions) from the CVA6Cfg parameter at runtime.
- Walks the tables one rule per cycle against a queried physical address and returns the three attribute flags.
- Serves debug/PMA-audit logic and the verification environment: a single sequential lookup port with ready/valid request and response handshakes.

Parameters:
- CVA6Cfg, config_pkg::cva6_cfg_empty, elaborated core configuration. Fields used:
  - NrExecuteRegionRules, ExecuteRegionAddrBase, ExecuteRegionLength
  - NrCachedRegionRules, CachedRegionAddrBase, CachedRegionLength
  - NrNonIdempotentRules, NonIdempotentAddrBase, NonIdempotentLength
- Derived localparam: NrRules = NrExecuteRegionRules + NrCachedRegionRules + NrNonIdempotentRules.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- flush_i  in  1  abort any lookup in progress
- query_valid_i  in  1  query request valid
- query_ready_o  out  1  block can accept a query
- query_addr_i  in  64  physical address to classify
- rsp_valid_o  out  1  result valid
- rsp_ready_i  in  1  consumer accepts the result
- rsp_addr_o  out  64  echoed query address
- rsp_exec_o  out  1  address lies in an Execute region
- rsp_cached_o  out  1  address lies in a Cached region
- rsp_nonidem_o  out  1  address lies in a NonIdempotent region

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset: state=IDLE, index=0, all flags=0, rsp_valid_o=0, rsp_addr_o=0, query_ready_o=1 after reset is released.
- Rule layout: rule i of each table occupies bits [64*i +: 64] of its 1024-bit base/length vectors.
- Global walk order: Execute rules 0..NE-1, then Cached rules 0..NC-1, then NonIdempotent rules 0..NN-1. Global index width is clog2(NrRules+1).
- Match: base <= addr < base + length, evaluated in 65-bit arithmetic so base+length cannot wrap.
  - length == 0 never matches.
  - The end address is exclusive.
- A match ORs into the flag of the table that owns the current rule. Matches are accumulated; the walk never terminates early.
- FSM:
  - IDLE: query_ready_o=1. On query_valid_i & query_ready_o: latch the address, clear the flags, index=0. Go to WALK if NrRules>0, else to RESP.
  - WALK: query_ready_o=0. Evaluate one rule per cycle, then index++. After evaluating rule NrRules-1, go to RESP.
  - RESP: rsp_valid_o=1, with outputs held stable until rsp_ready_i. On the handshake, go to IDLE.
  - No query is accepted in the cycle the response handshakes, so there is one bubble cycle.
- Latency: with acceptance at edge 0, rsp_valid_o rises after edge NrRules+1. With the default config (NrRules=6), that is 7 cycles.
- Backpressure: while RESP waits for rsp_ready_i, all rsp_* outputs stay constant and query_ready_o=0.
- flush_i:
  - In WALK or RESP, the next state is IDLE, rsp_valid_o drops, and the result is discarded.
  - In IDLE, flush_i has priority over a simultaneous query: the query is not accepted and query_ready_o is still 1.
- Query addresses are compared at the full 64-bit width. No alignment requirement applies.
- Asserting reset mid-walk returns to IDLE immediately. No response is produced for the aborted query.

Test Plan:
- Default config, addr 0x0000_0000_8000_1000 -> rsp_exec=1, cached=1, nonidem=0, rsp_addr echoed; rsp_valid 7 cycles after the query handshake.
- addr 0x0000_0000_C000_0000 (end of the 0x8000_0000+0x4000_0000 region, exclusive) -> exec=0, cached=0, nonidem=0.
- addr 0x0FFF -> exec=1 only. addr 0x1000 -> all 0. addr 0x1_FFFF -> exec=1 only.
- Hold rsp_ready_i=0 for 5 cycles with addr 0x8000_0000 -> rsp_valid and flags stable throughout, query_ready_o=0. Release -> query_ready_o=1 on the following cycle.
- Assert flush_i in WALK cycle 3 -> no response ever appears, query_ready_o=1 next cycle. A new query for 0x10000 -> exec=1 only, correct latency.
- Override config: NonIdempotent rule 0 with base 0xFFFF_FFFF_FFFF_F000, length 0x2000; addr 0xFFFF_FFFF_FFFF_FFF8 -> nonidem=1, no overflow false-negative. All-zero rule-count config -> response 1 cycle after acceptance with all flags 0.

Source files
------------

// File: rtl/cfg_region_query.sv
// Minimal core-configuration package plus the PMA region query block.
// The package carries only the fields the query walks; the default
// configuration mirrors the usual 64-bit CVA6 PMA layout (6 rules).

package config_pkg;

    typedef struct packed {
        int unsigned   NrExecuteRegionRules;
        logic [1023:0] ExecuteRegionAddrBase;
        logic [1023:0] ExecuteRegionLength;
        int unsigned   NrCachedRegionRules;
        logic [1023:0] CachedRegionAddrBase;
        logic [1023:0] CachedRegionLength;
        int unsigned   NrNonIdempotentRules;
        logic [1023:0] NonIdempotentAddrBase;
        logic [1023:0] NonIdempotentLength;
    } cva6_cfg_t;

    // Debug (0x0), boot ROM (0x1_0000) and DRAM (0x8000_0000) are executable,
    // DRAM is cached, and the two NonIdempotent slots are zero-length.
    localparam cva6_cfg_t cva6_cfg_empty = '{
        NrExecuteRegionRules:  3,
        ExecuteRegionAddrBase: 1024'({64'h0000_0000_8000_0000, 64'h0000_0000_0001_0000, 64'h0}),
        ExecuteRegionLength:   1024'({64'h0000_0000_4000_0000, 64'h0000_0000_0001_0000, 64'h1000}),
        NrCachedRegionRules:   1,
        CachedRegionAddrBase:  1024'(64'h0000_0000_8000_0000),
        CachedRegionLength:    1024'(64'h0000_0000_4000_0000),
        NrNonIdempotentRules:  2,
        NonIdempotentAddrBase: '0,
        NonIdempotentLength:   '0
    };

endpackage

// Sequential PMA lookup: one rule per cycle across the Execute, Cached and
// NonIdempotent tables, result returned over a ready/valid response port.
module cfg_region_query #(
    parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
    input  logic        query_valid_i,
    output logic        query_ready_o,
    input  logic [63:0] query_addr_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [63:0] rsp_addr_o,
    output logic        rsp_exec_o,
    output logic        rsp_cached_o,
    output logic        rsp_nonidem_o
);

    localparam int NE       = int'(CVA6Cfg.NrExecuteRegionRules);
    localparam int NC       = int'(CVA6Cfg.NrCachedRegionRules);
    localparam int NN       = int'(CVA6Cfg.NrNonIdempotentRules);
    localparam int NrRules  = NE + NC + NN;
    localparam int IdxW     = (NrRules > 0) ? $clog2(NrRules + 1) : 1;
    localparam int LastRule = (NrRules > 0) ? NrRules - 1 : 0;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WALK = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]      state;
    logic [IdxW-1:0] rule_idx;
    logic [63:0]     addr_q;
    logic            exec_q;
    logic            cached_q;
    logic            nonidem_q;
    logic            valid_q;

    logic [63:0]     cur_base;
    logic [63:0]     cur_len;
    logic [2:0]      cur_sel;
    logic [64:0]     cur_end;
    logic            rule_hit;

    // Select the base/length of the rule at the current global index and tag its owning table
    always_comb begin
        cur_base = '0;
        cur_len  = '0;
        cur_sel  = 3'b000;
        for (int i = 0; i < NE; i++) begin
            if (rule_idx == IdxW'(i)) begin
                cur_base = CVA6Cfg.ExecuteRegionAddrBase[64*i +: 64];
                cur_len  = CVA6Cfg.ExecuteRegionLength[64*i +: 64];
                cur_sel  = 3'b001;
            end
        end
        for (int i = 0; i < NC; i++) begin
            if (rule_idx == IdxW'(NE + i)) begin
                cur_base = CVA6Cfg.CachedRegionAddrBase[64*i +: 64];
                cur_len  = CVA6Cfg.CachedRegionLength[64*i +: 64];
                cur_sel  = 3'b010;
            end
        end
        for (int i = 0; i < NN; i++) begin
            if (rule_idx == IdxW'(NE + NC + i)) begin
                cur_base = CVA6Cfg.NonIdempotentAddrBase[64*i +: 64];
                cur_len  = CVA6Cfg.NonIdempotentLength[64*i +: 64];
                cur_sel  = 3'b100;
            end
        end
    end

    // Range test in 65 bits so a region touching the top of memory cannot wrap
    always_comb begin
        cur_end  = {1'b0, cur_base} + {1'b0, cur_len};
        rule_hit = (cur_len != 64'd0)
                && ({1'b0, addr_q} >= {1'b0, cur_base})
                && ({1'b0, addr_q} < cur_end);
    end

    // Query FSM: accept, walk every rule accumulating flags, then present the result.
    // RESP spends one settle cycle before raising valid so latency is NrRules+1 in all configs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            rule_idx  <= '0;
            addr_q    <= '0;
            exec_q    <= 1'b0;
            cached_q  <= 1'b0;
            nonidem_q <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (query_valid_i && !flush_i) begin
                        addr_q    <= query_addr_i;
                        exec_q    <= 1'b0;
                        cached_q  <= 1'b0;
                        nonidem_q <= 1'b0;
                        rule_idx  <= '0;
                        state     <= (NrRules > 0) ? WALK : RESP;
                    end
                end
                WALK: begin
                    if (flush_i) begin
                        state <= IDLE;
                    end else begin
                        exec_q    <= exec_q    | (rule_hit & cur_sel[0]);
                        cached_q  <= cached_q  | (rule_hit & cur_sel[1]);
                        nonidem_q <= nonidem_q | (rule_hit & cur_sel[2]);
                        rule_idx  <= rule_idx + 1'b1;
                        if (rule_idx == IdxW'(LastRule)) begin
                            state <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (flush_i) begin
                        state   <= IDLE;
                        valid_q <= 1'b0;
                    end else if (!valid_q) begin
                        valid_q <= 1'b1;
                    end else if (rsp_ready_i) begin
                        state   <= IDLE;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign query_ready_o = (state == IDLE);
    assign rsp_valid_o   = valid_q;
    assign rsp_addr_o    = addr_q;
    assign rsp_exec_o    = exec_q;
    assign rsp_cached_o  = cached_q;
    assign rsp_nonidem_o = nonidem_q;

endmodule

// File: tb/tb_cfg_region_query.sv
// Directed bench for cfg_region_query: default, top-of-memory and empty configs.
module tb_cfg_region_query;

    localparam config_pkg::cva6_cfg_t CfgWrap = '{
        NrExecuteRegionRules:  1,
        ExecuteRegionAddrBase: 1024'(64'h0),
        ExecuteRegionLength:   1024'(64'h1000),
        NrCachedRegionRules:   0,
        CachedRegionAddrBase:  '0,
        CachedRegionLength:    '0,
        NrNonIdempotentRules:  1,
        NonIdempotentAddrBase: 1024'(64'hFFFF_FFFF_FFFF_F000),
        NonIdempotentLength:   1024'(64'h2000)
    };
    localparam config_pkg::cva6_cfg_t CfgZero = '0;

    typedef struct {
        logic [63:0] addr;
        logic        e;
        logic        c;
        logic        n;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush     [3];
    logic        q_valid   [3];
    logic        q_ready   [3];
    logic [63:0] q_addr    [3];
    logic        rsp_valid [3];
    logic        rsp_ready [3];
    logic [63:0] rsp_addr  [3];
    logic        rsp_exec  [3];
    logic        rsp_cached[3];
    logic        rsp_nonid [3];

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Free-running clock
    always #5 clk = ~clk;

    cfg_region_query dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush[0]),
        .query_valid_i(q_valid[0]), .query_ready_o(q_ready[0]), .query_addr_i(q_addr[0]),
        .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready[0]), .rsp_addr_o(rsp_addr[0]),
        .rsp_exec_o(rsp_exec[0]), .rsp_cached_o(rsp_cached[0]), .rsp_nonidem_o(rsp_nonid[0])
    );

    cfg_region_query #(.CVA6Cfg(CfgWrap)) dut_wrap (
        .clk_i(clk), .rst_i(rst), .flush_i(flush[1]),
        .query_valid_i(q_valid[1]), .query_ready_o(q_ready[1]), .query_addr_i(q_addr[1]),
        .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready[1]), .rsp_addr_o(rsp_addr[1]),
        .rsp_exec_o(rsp_exec[1]), .rsp_cached_o(rsp_cached[1]), .rsp_nonidem_o(rsp_nonid[1])
    );

    cfg_region_query #(.CVA6Cfg(CfgZero)) dut_zero (
        .clk_i(clk), .rst_i(rst), .flush_i(flush[2]),
        .query_valid_i(q_valid[2]), .query_ready_o(q_ready[2]), .query_addr_i(q_addr[2]),
        .rsp_valid_o(rsp_valid[2]), .rsp_ready_i(rsp_ready[2]), .rsp_addr_o(rsp_addr[2]),
        .rsp_exec_o(rsp_exec[2]), .rsp_cached_o(rsp_cached[2]), .rsp_nonidem_o(rsp_nonid[2])
    );

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one query, measure latency, compare against the scoreboard, optionally backpressure
    task automatic apply_stimulus(input int u, input logic [63:0] addr, input int exp_lat,
                                  input logic e, input logic c, input logic n, input int hold);
        exp_t ex;
        int   k;
        bit   seen;
        ex.addr = addr;
        ex.e    = e;
        ex.c    = c;
        ex.n    = n;
        sb.push_back(ex);
        k = 0;
        while (q_ready[u] !== 1'b1 && k < 50) begin
            tick();
            k++;
        end
        check_output("ready_before_query", 64'(q_ready[u]), 64'd1);
        rsp_ready[u] = (hold == 0);
        q_valid[u]   = 1'b1;
        q_addr[u]    = addr;
        tick();
        q_valid[u]   = 1'b0;
        q_addr[u]    = 64'hDEAD_BEEF_DEAD_BEEF;
        seen = 0;
        k    = 0;
        while (!seen && k < 200) begin
            tick();
            k++;
            if (rsp_valid[u] === 1'b1) seen = 1;
        end
        check_output("latency", 64'(k), 64'(exp_lat));
        ex = sb.pop_front();
        check_output("rsp_addr", rsp_addr[u], ex.addr);
        check_output("rsp_exec", 64'(rsp_exec[u]), 64'(ex.e));
        check_output("rsp_cached", 64'(rsp_cached[u]), 64'(ex.c));
        check_output("rsp_nonidem", 64'(rsp_nonid[u]), 64'(ex.n));
        for (int h = 0; h < hold; h++) begin
            tick();
            check_output("hold_valid", 64'(rsp_valid[u]), 64'd1);
            check_output("hold_ready", 64'(q_ready[u]), 64'd0);
            check_output("hold_addr", rsp_addr[u], ex.addr);
            check_output("hold_flags", {61'd0, rsp_exec[u], rsp_cached[u], rsp_nonid[u]},
                         {61'd0, ex.e, ex.c, ex.n});
        end
        rsp_ready[u] = 1'b1;
        tick();
        check_output("post_hs_valid", 64'(rsp_valid[u]), 64'd0);
        check_output("post_hs_ready", 64'(q_ready[u]), 64'd1);
    endtask

    // Count cycles in which an instance raises rsp_valid over a fixed window
    task automatic count_valid(input int u, input int cycles, output int hits);
        hits = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (rsp_valid[u] !== 1'b0) hits++;
        end
    endtask

    // Hard stop if the sequence ever stalls
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    // Directed sequence
    initial begin
        int hits;
        for (int u = 0; u < 3; u++) begin
            flush[u]     = 1'b0;
            q_valid[u]   = 1'b0;
            q_addr[u]    = '0;
            rsp_ready[u] = 1'b1;
        end
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        check_output("reset_ready", 64'(q_ready[0]), 64'd1);
        check_output("reset_valid", 64'(rsp_valid[0]), 64'd0);
        check_output("reset_addr", rsp_addr[0], 64'd0);
        check_output("reset_flags", {61'd0, rsp_exec[0], rsp_cached[0], rsp_nonid[0]}, 64'd0);
        check_output("reset_ready_wrap", 64'(q_ready[1]), 64'd1);
        check_output("reset_ready_zero", 64'(q_ready[2]), 64'd1);

        apply_stimulus(0, 64'h0000_0000_8000_1000, 7, 1'b1, 1'b1, 1'b0, 0);
        apply_stimulus(0, 64'h0000_0000_C000_0000, 7, 1'b0, 1'b0, 1'b0, 0);
        apply_stimulus(0, 64'h0000_0000_0000_0FFF, 7, 1'b1, 1'b0, 1'b0, 0);
        apply_stimulus(0, 64'h0000_0000_0000_1000, 7, 1'b0, 1'b0, 1'b0, 0);
        apply_stimulus(0, 64'h0000_0000_0001_FFFF, 7, 1'b1, 1'b0, 1'b0, 0);
        apply_stimulus(0, 64'h0000_0000_8000_0000, 7, 1'b1, 1'b1, 1'b0, 5);

        q_valid[0] = 1'b1;
        q_addr[0]  = 64'h0000_0000_8000_1000;
        tick();
        q_valid[0] = 1'b0;
        check_output("walk_ready_low", 64'(q_ready[0]), 64'd0);
        tick();
        flush[0] = 1'b1;
        tick();
        flush[0] = 1'b0;
        check_output("flush_walk_ready", 64'(q_ready[0]), 64'd1);
        count_valid(0, 12, hits);
        check_output("flush_walk_no_rsp", 64'(hits), 64'd0);
        apply_stimulus(0, 64'h0000_0000_0001_0000, 7, 1'b1, 1'b0, 1'b0, 0);

        flush[0]   = 1'b1;
        q_valid[0] = 1'b1;
        q_addr[0]  = 64'h0000_0000_8000_2000;
        tick();
        flush[0]   = 1'b0;
        q_valid[0] = 1'b0;
        check_output("flush_idle_ready", 64'(q_ready[0]), 64'd1);
        check_output("flush_idle_addr", rsp_addr[0], 64'h0000_0000_0001_0000);
        count_valid(0, 10, hits);
        check_output("flush_idle_no_rsp", 64'(hits), 64'd0);

        apply_stimulus(1, 64'hFFFF_FFFF_FFFF_FFF8, 3, 1'b0, 1'b0, 1'b1, 0);
        apply_stimulus(1, 64'hFFFF_FFFF_FFFF_EFF8, 3, 1'b0, 1'b0, 1'b0, 0);
        apply_stimulus(1, 64'h0000_0000_0000_0800, 3, 1'b1, 1'b0, 1'b0, 0);
        apply_stimulus(2, 64'h0000_0000_0000_1234, 1, 1'b0, 1'b0, 1'b0, 0);

        q_valid[0] = 1'b1;
        q_addr[0]  = 64'h0000_0000_8000_1000;
        tick();
        q_valid[0] = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        check_output("midwalk_reset_ready", 64'(q_ready[0]), 64'd1);
        check_output("midwalk_reset_addr", rsp_addr[0], 64'd0);
        tick();
        rst = 1'b0;
        count_valid(0, 12, hits);
        check_output("midwalk_reset_no_rsp", 64'(hits), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
